mc_datapath_bus: RTL and testbench

Parametrised multi-cycle RISC-V datapath that replaces the zero-wait-state instruction memory path with a ready/valid memory bus. It accepts the same per-state control signals from the multi-cycle controller and adds a bus sequencer, byte/halfword load-store alignment, and a stall output. Width, register count and reset vector are parametrised. It sits between the controller FSM and a shared instruction/data memory.

---
 rtl/mc_pkg.sv | 43 ++++
 rtl/mem_bus_if.sv | 86 ++++++++
 rtl/mc_datapath_bus.sv | 132 +++++++++++++
 tb/tb_mc_datapath_bus.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings, bus FSM state and alignment/extension helpers for the multi-cycle datapath
package mc_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10} result_src_e;
  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_A = 2'b10} alu_src_a_e;
  typedef enum logic [1:0] {SRCB_WD = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_e;
  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} mem_size_e;
  typedef enum logic {BUS_IDLE = 1'b0, BUS_REQ = 1'b1} bus_state_e;

  // lo is the byte offset within a 64-bit beat; doubles are legal only on RV64
  function automatic logic is_aligned(input logic [2:0] lo, input mem_size_e sz, input logic rv64);
    return sz == SZ_B ? 1'b1 :
           sz == SZ_H ? !lo[0] :
           sz == SZ_W ? lo[1:0] == 2'b00 :
           rv64 && lo == 3'b000;
  endfunction

  function automatic logic [7:0] byte_mask(input logic [2:0] lo, input mem_size_e sz);
    logic [7:0] m;
    m = sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0f : 8'hff;
    return m << lo;
  endfunction

  function automatic logic [63:0] load_ext(input logic [63:0] v, input mem_size_e sz, input logic uns);
    return sz == SZ_B ? {{56{!uns && v[7]}}, v[7:0]} :
           sz == SZ_H ? {{48{!uns && v[15]}}, v[15:0]} :
           sz == SZ_W ? {{32{!uns && v[31]}}, v[31:0]} :
           v;
  endfunction

endpackage

// File: rtl/mem_bus_if.sv
// mem_bus_if: ready/valid bus sequencer with store lane steering, strobes, load extension and the Data register
module mem_bus_if
  import mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic              fetch,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store,
  output logic              busy,
  output logic              misalign,
  output logic              fetch_done,
  output logic [XLEN-1:0]   data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB = XLEN / 8;

  bus_state_e state;
  mem_size_e sz, r_sz;
  logic [2:0] lo, r_lo;
  logic ok, launch, done, r_uns, r_fetch;
  logic [NB-1:0] strb;
  logic [XLEN-1:0] lane_wdata, shifted, loaded;

  always_comb begin
    sz = mem_size_e'(size);
    lo = XLEN == 64 ? addr[2:0] : {1'b0, addr[1:0]};
    ok = is_aligned(lo, sz, XLEN == 64);
    launch = state == BUS_IDLE && start && ok;
    busy = launch || state == BUS_REQ;
    misalign = !reset && state == BUS_IDLE && start && !ok;
    done = state == BUS_REQ && mem_ready;
    fetch_done = done && r_fetch && !mem_we;
    mem_req = state == BUS_REQ;
    strb = NB'(byte_mask(lo, sz));
    lane_wdata = sz == SZ_B ? {NB{store[7:0]}} :
                 sz == SZ_H ? {(NB/2){store[15:0]}} :
                 sz == SZ_W ? {(NB/4){store[31:0]}} :
                 store;
    shifted = mem_rdata >> {r_lo, 3'b000};
    loaded = XLEN'(load_ext(64'(shifted), r_sz, r_uns));
  end

  // request fields are frozen at launch so they stay stable for the whole REQ phase
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BUS_IDLE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      data <= '0;
      r_sz <= SZ_B;
      r_lo <= '0;
      r_uns <= 1'b0;
      r_fetch <= 1'b0;
    end else if (launch) begin
      state <= BUS_REQ;
      mem_we <= we;
      mem_addr <= addr;
      mem_wdata <= lane_wdata;
      mem_wstrb <= we ? strb : '0;
      r_sz <= sz;
      r_lo <= lo;
      r_uns <= uns;
      r_fetch <= fetch;
    end else if (done) begin
      state <= BUS_IDLE;
      if (!mem_we) data <= loaded;
    end
  end

endmodule

// File: rtl/mc_datapath_bus.sv
// mc_datapath_bus: multi-cycle RISC-V datapath whose shared memory is reached through a ready/valid bus
module mc_datapath_bus
  import mc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              IRWrite,
  input  logic              RegWrite,
  input  logic              AdrSrc,
  input  logic              MemStart,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemUnsigned,
  input  logic [1:0]        ResultSrc,
  input  logic [1:0]        ALUSrcA,
  input  logic [1:0]        ALUSrcB,
  input  logic [1:0]        ImmSrc,
  input  logic [2:0]        ALUControl,
  output logic [6:0]        op,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic              Zero,
  output logic [XLEN-1:0]   PC,
  output logic              MemBusy,
  output logic              MisalignErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(XLEN);

  logic [31:0] instr;
  logic [XLEN-1:0] old_pc, a, write_data, alu_out, data;
  logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result, adr;
  logic [XLEN-1:0] rf [NREGS];
  logic [AW-1:0] rs1, rs2, rd;
  logic fetch_done;

  assign op = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1 = instr[15 +: AW];
  assign rs2 = instr[20 +: AW];
  assign rd = instr[7 +: AW];
  assign rd1 = rs1 == '0 ? '0 : rf[rs1];
  assign rd2 = rs2 == '0 ? '0 : rf[rs2];
  assign adr = AdrSrc ? result : PC;
  assign Zero = alu_result == '0;

  always_comb begin
    imm_ext = ImmSrc == IMM_I ? {{(XLEN-12){instr[31]}}, instr[31:20]} :
              ImmSrc == IMM_S ? {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]} :
              ImmSrc == IMM_B ? {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
              {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    src_a = ALUSrcA == SRCA_PC ? PC : ALUSrcA == SRCA_OLDPC ? old_pc : a;
    src_b = ALUSrcB == SRCB_WD ? write_data : ALUSrcB == SRCB_IMM ? imm_ext : XLEN'(3'd4);
    result = ResultSrc == RES_ALUOUT ? alu_out : ResultSrc == RES_DATA ? data : alu_result;
  end

  always_comb begin
    case (alu_op_e'(ALUControl))
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLL: alu_result = src_a << src_b[SW-1:0];
      default: alu_result = src_a >> src_b[SW-1:0];
    endcase
  end

  // architectural registers survive reset
  always_ff @(posedge clk) begin
    if (RegWrite && !MemBusy && rd != '0) rf[rd] <= result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC <= RESET_PC;
      instr <= '0;
      old_pc <= '0;
      a <= '0;
      write_data <= '0;
      alu_out <= '0;
    end else begin
      a <= rd1;
      write_data <= rd2;
      alu_out <= alu_result;
      if (PCWrite && !MemBusy) PC <= result;
      if (fetch_done) begin
        instr <= mem_rdata[31:0];
        old_pc <= PC;
      end
    end
  end

  mem_bus_if #(.XLEN(XLEN)) u_bus (
    .clk       (clk),
    .reset     (reset),
    .start     (MemStart),
    .we        (MemWrite),
    .size      (MemSize),
    .uns       (MemUnsigned),
    .fetch     (IRWrite),
    .addr      (adr),
    .store     (write_data),
    .busy      (MemBusy),
    .misalign  (MisalignErr),
    .fetch_done(fetch_done),
    .data      (data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

endmodule

// File: tb/tb_mc_datapath_bus.sv
// tb_mc_datapath_bus: randomized bus accesses checked against a behavioural memory-path model
module tb_mc_datapath_bus;

  logic clk = 1'b0;
  logic reset, PCWrite, IRWrite, RegWrite, AdrSrc, MemStart, MemWrite, MemUnsigned;
  logic [1:0] MemSize, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [6:0] op, funct7;
  logic [2:0] funct3;
  logic Zero, MemBusy, MisalignErr, mem_req, mem_we, mem_ready;
  logic [31:0] PC, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_pc, m_data, m_instr, m_oldpc;
  logic [31:0] m_rf [32];

  always #5 clk = ~clk;

  mc_datapath_bus #(.XLEN(32), .NREGS(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .MemStart(MemStart), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemUnsigned(MemUnsigned), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .PC(PC), .MemBusy(MemBusy), .MisalignErr(MisalignErr), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int bits;
    logic [31:0] v, mask;
    bits = 8 << sz;
    v = rd >> (8 * (a % 4));
    if (bits < 32) begin
      mask = (32'd1 << bits) - 32'd1;
      v = v & mask;
      if (!uns && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] operand, input logic [1:0] sz);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = operand[8*(i % (1 << sz)) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = (i >= a % 4) && (i < a % 4 + (1 << sz));
    return s;
  endfunction

  task automatic bus_op(input logic wr, input logic [1:0] sz, input logic uns, input logic adr_src,
                        input logic fetch, input logic [31:0] rdata, input int lat);
    logic [31:0] addr, operand;
    logic ok;
    addr = adr_src ? m_data : m_pc;
    ok = (sz != 2'd3) && (addr % (1 << sz) == 0);
    operand = m_rf[m_instr[24:20]];
    MemStart = 1; MemWrite = wr; MemSize = sz; MemUnsigned = uns; AdrSrc = adr_src; IRWrite = fetch;
    ResultSrc = fetch ? 2'd2 : 2'd1; ALUSrcA = 2'd0; ALUSrcB = 2'd2; ALUControl = 3'd0; PCWrite = fetch;
    #1;
    chk("busy_start", MemBusy, ok);
    chk("misalign_err", MisalignErr, !ok);
    step;
    MemStart = 0;
    if (!ok) begin
      IRWrite = 0;
      PCWrite = 0;
      chk("req_after_err", mem_req, 0);
      chk("busy_after_err", MemBusy, 0);
      return;
    end
    for (int k = 1; k <= lat; k++) begin
      mem_ready = (k == lat);
      mem_rdata = (k == lat) ? rdata : $urandom;
      #1;
      chk("req", mem_req, 1);
      chk("addr", mem_addr, addr);
      chk("we", mem_we, wr);
      chk("busy", MemBusy, 1);
      if (wr) begin
        chk("wdata", mem_wdata, exp_wdata(operand, sz));
        chk("wstrb", mem_wstrb, exp_wstrb(addr, sz));
      end
      if (fetch) chk("pc_hold", PC, m_pc);
      step;
    end
    mem_ready = 0;
    IRWrite = 0;
    #1;
    chk("req_done", mem_req, 0);
    chk("busy_done", MemBusy, 0);
    if (!wr) m_data = exp_load(rdata, addr, sz, uns);
    if (fetch) begin
      m_instr = rdata;
      m_oldpc = m_pc;
      chk("op", op, m_instr[6:0]);
      chk("funct3", funct3, m_instr[14:12]);
      chk("funct7", funct7, m_instr[31:25]);
      step;
      PCWrite = 0;
      chk("pc_inc", PC, m_pc + 4);
      m_pc = m_pc + 4;
    end
  endtask

  task automatic pc_zero;
    ResultSrc = 2'd2; ALUSrcA = 2'd2; ALUSrcB = 2'd1; ALUControl = 3'd2; PCWrite = 1;
    #1;
    chk("zero_flag", Zero, 1);
    step;
    PCWrite = 0;
    chk("pc_zero", PC, 0);
    m_pc = 0;
  endtask

  task automatic peek_data;
    ResultSrc = 2'd1; PCWrite = 1;
    step;
    PCWrite = 0;
    chk("data", PC, m_data);
    m_pc = m_data;
  endtask

  task automatic peek_oldpc;
    logic [31:0] e;
    e = m_oldpc + {{20{m_instr[31]}}, m_instr[31:20]};
    ResultSrc = 2'd2; ALUSrcA = 2'd1; ALUSrcB = 2'd1; ALUControl = 3'd0; PCWrite = 1;
    #1;
    chk("zero_oldpc", Zero, e == 0);
    step;
    PCWrite = 0;
    chk("oldpc", PC, e);
    m_pc = e;
  endtask

  task automatic reg_write;
    RegWrite = 1; ResultSrc = 2'd1;
    step;
    RegWrite = 0;
    if (m_instr[11:7] != 0) m_rf[m_instr[11:7]] = m_data;
  endtask

  task automatic do_mem(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] x, input logic [31:0] v, input logic [31:0] rdata, input int lat);
    bus_op(0, 2'd2, 0, 0, 0, v, $urandom_range(1, 2));
    reg_write;
    bus_op(0, 2'd2, 0, 0, 0, x, 1);
    bus_op(wr, sz, uns, 1, 0, rdata, lat);
    peek_data;
    pc_zero;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; PCWrite = 0; IRWrite = 0; RegWrite = 0; AdrSrc = 0; MemStart = 0; MemWrite = 0;
    MemUnsigned = 0; MemSize = 0; ResultSrc = 0; ALUSrcA = 0; ALUSrcB = 0; ImmSrc = 0;
    ALUControl = 0; mem_ready = 0; mem_rdata = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    step;
    step;
    reset = 0;
    m_pc = 32'h100; m_data = 0; m_instr = 0; m_oldpc = 0;
    chk("rst_pc", PC, 32'h100);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", MemBusy, 0);
    chk("rst_op", op, 0);
    chk("rst_funct7", funct7, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_misalign", MisalignErr, 0);
    pc_zero;
    bus_op(0, 2'd2, 0, 0, 1, 32'h00500093, 3);
    peek_oldpc;
    pc_zero;
    bus_op(0, 2'd2, 0, 0, 1, 32'h00200113, 1);
    pc_zero;
    do_mem(0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF0000, 2);
    chk("lb_signed", m_data, 32'hFFFFFF80);
    do_mem(0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF0000, 1);
    chk("lbu", m_data, 32'h00000080);
    do_mem(1, 2'd1, 0, 32'h102, 32'h0000BEEF, 32'h0, 3);
    do_mem(0, 2'd2, 0, 32'h101, 32'h0, 32'h12345678, 1);
    chk("misaligned_data_kept", m_data, 32'h101);
    for (int i = 0; i < 40; i++)
      do_mem($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
             $urandom & 32'hFFF, $urandom, $urandom, $urandom_range(1, 4));
    MemStart = 1; MemSize = 2'd2; MemWrite = 0; AdrSrc = 0; ResultSrc = 2'd1;
    step;
    MemStart = 0;
    step;
    reset = 1;
    #1;
    chk("req_before_rst", mem_req, 1);
    step;
    reset = 0;
    mem_ready = 1;
    mem_rdata = $urandom;
    #1;
    chk("req_after_rst", mem_req, 0);
    chk("busy_after_rst", MemBusy, 0);
    step;
    mem_ready = 0;
    chk("req_late_ready", mem_req, 0);
    chk("pc_after_rst", PC, 32'h100);
    chk("op_after_rst", op, 0);
    m_pc = 32'h100; m_data = 0; m_instr = 0; m_oldpc = 0;
    peek_data;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
